// File: rtl/mmio_out_port.sv
// mmio_out_port: bus-mapped output port, CPU stores queue words to a stream sink.
// Define MMIO_OUT_IRQ_EN to add the CTRL register and the irq output.
module mmio_out_port #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'hF0,
  parameter int                DEPTH     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              boot,
  input  logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef MMIO_OUT_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [ADDR_W-1:0] DATA_A = BASE_ADDR;
  localparam logic [ADDR_W-1:0] STAT_A = BASE_ADDR + ADDR_W'(1);
`ifdef MMIO_OUT_IRQ_EN
  localparam logic [ADDR_W-1:0] CTRL_A = BASE_ADDR + ADDR_W'(2);
`endif

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;

  logic              sel_data;
  logic              sel_stat;
  logic              sel_ctrl;
  logic              bus_wr;
  logic              bus_rd;
  logic              push_req;
  logic              push_ok;
  logic              pop;
  logic              full;
  logic              empty;
  logic              rd_hit;
  logic [DATA_W-1:0] rd_val;

`ifdef MMIO_OUT_IRQ_EN
  logic              irq_en_q, irq_en_d;
  logic              irq_q, irq_d;
  assign sel_ctrl = (addr == CTRL_A);
`else
  assign sel_ctrl = 1'b0;
`endif

  assign sel_data = (addr == DATA_A);
  assign sel_stat = (addr == STAT_A);
  assign bus_wr   = !boot && wr_en;
  assign bus_rd   = !boot && !wr_en;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);

  assign out_valid = !empty;
  assign out_data  = mem_q[rd_ptr_q];

  assign pop      = out_valid && out_ready;
  assign push_req = bus_wr && sel_data;
  // A full FIFO still takes a word if the head leaves this same cycle.
  assign push_ok  = push_req && (!full || pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push_req && !push_ok) begin
      ovf_d = 1'b1;
    end else if (bus_wr && sel_stat) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data;
      end
    end
  end

`ifdef MMIO_OUT_IRQ_EN
  always_comb begin
    irq_en_d = irq_en_q;
    if (bus_wr && sel_ctrl) begin
      irq_en_d = data[0];
    end
    irq_d = irq_en_q && empty;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

  always_comb begin
    rd_hit = 1'b0;
    rd_val = '0;
    if (bus_rd) begin
      unique case (1'b1)
        sel_data: begin
          rd_hit = 1'b1;
        end
        sel_stat: begin
          rd_hit    = 1'b1;
          rd_val[0] = full;
          rd_val[1] = empty;
          rd_val[2] = ovf_q;
          rd_val[7:3] = 5'(count_q);
        end
`ifdef MMIO_OUT_IRQ_EN
        sel_ctrl: begin
          rd_hit    = 1'b1;
          rd_val[0] = irq_en_q;
        end
`endif
        default: begin
          rd_hit = 1'b0;
        end
      endcase
    end
  end

  // ROM-style read: the bus is only ours while a decoded read is in flight.
  assign data = rd_hit ? rd_val : {DATA_W{1'bz}};

endmodule

// File: doc/mmio_out_port.md
Name: mmio_out_port

Overview:
- Memory-mapped output peripheral that acts as a responder on the shared CPU address/data bus, alongside RAM and ROM.
- CPU stores to the data register push words into a 4-entry FIFO.
- The FIFO drains to an external sink over a valid/ready stream.
- CPU loads from the status register return FIFO state, so software can poll before writing.

Parameters:
- ADDR_W, 8, address bus width; tie to `ADDR_SIZE at instantiation.
- DATA_W, 8, data bus width; tie to `WORD_SIZE at instantiation. Must be >= 8.
- BASE_ADDR, 8'hF0, address of the data register.
- DEPTH, 4, FIFO depth; power of two, 2..16.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-low.
- wr_en  input  1  bus write strobe from the CPU (1 = write, 0 = read).
- boot  input  1  boot flag from the CPU; while high, the block is invisible on the bus.
- addr  input  ADDR_W  shared address bus.
- data  inout  DATA_W  shared data bus; driven only during a decoded read, otherwise 'z.
- out_data  output  DATA_W  FIFO head word.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  sink accepts the head word this cycle.

Behaviour:
Register map:
- BASE_ADDR+0, DATA. Write pushes a word. Read returns 0.
- BASE_ADDR+1, STATUS. Read returns:
  - bit0 = full
  - bit1 = empty
  - bit2 = overflow (sticky)
  - bits[7:3] = count (zero-extended)
  - upper bits = 0.
  Writing any value clears overflow.
- Any other address: no decode, bus stays 'z.

Bus rules:
- Reads are combinational, ROM-style. data is driven when boot=0, wr_en=0 and addr decodes; otherwise data is 'z. Never drive data while wr_en=1.
- Writes are sampled at posedge clk when boot=0, wr_en=1 and addr decodes.
- While boot=1, all bus writes are ignored. The stream side keeps draining.

FIFO:
- Pointers: rd_ptr and wr_ptr, each log2(DEPTH) bits, wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Pop when out_valid && out_ready. Push on a decoded DATA write.
- Push accepted when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle (count unchanged).
- Push rejected when full with no pop. On rejection: data is dropped and overflow is set. FIFO contents and pointers are unchanged.
- Simultaneous push and pop with count=0 is impossible because out_valid=0. The word is written, and out_valid rises next cycle.

Stream side:
- out_data = mem[rd_ptr] (registered storage, combinational read). out_valid = (count != 0).
- Write-to-valid latency is 1 cycle: the word is written at edge N, and out_valid is high after edge N.
- The sink may hold out_ready low indefinitely. out_data must stay stable while out_valid=1 and no pop occurs.

Reset (rst=0 at posedge):
- count=0, rd_ptr=0, wr_ptr=0, overflow=0.
- out_valid=0, out_data=don't-care (implementation drives 0 from a cleared mem[0]; mem is cleared at reset).
- data bus released.
- Reset mid-stream discards all queued words.
- Reset has priority over a simultaneous push or pop.

Optional Feature:
Macro MMIO_OUT_IRQ_EN.
- Defined:
  - Adds port irq (output, 1).
  - Adds register BASE_ADDR+2, CTRL. Bit0 = irq_en, read/write; other bits read 0.
  - irq = irq_en && empty, registered: updates the cycle after the condition changes.
  - Reset clears irq_en and irq.
- Undefined:
  - No irq port. BASE_ADDR+2 is not decoded (bus 'z).

Test Plan:
1. Reset, then read STATUS at 8'hF1 with boot=0 -> data=8'b0000_0010 (empty); out_valid=0.
2. Write 8'hA5, 8'h3C to 8'hF0 with out_ready=0 -> out_valid=1 one cycle after the first write; out_data=8'hA5; STATUS=8'b0001_0000 (count=2). Raise out_ready for 2 cycles -> pops A5 then 3C; out_valid=0; STATUS=8'h02.
3. With out_ready=0, write 5 words 1..5 -> STATUS=8'b0010_0101 (count=4, overflow, full). Drain -> 1,2,3,4 in order. Write 8'h00 to 8'hF1 -> overflow clears, STATUS=8'h02.
4. Fill to full; next cycle assert out_ready=1 and write 8'h77 in the same cycle -> 1 popped, 8'h77 accepted, count stays 4, overflow stays 0. 8'h77 emerges 4th.
5. boot=1: write 8'h11 to 8'hF0 and read 8'hF1 -> no push, data remains 'z. Also drive addr=8'hF3 with boot=0 -> data remains 'z.
6. Queue 3 words, assert rst=0 for one cycle mid-drain -> next cycle out_valid=0, STATUS=8'h02. With MMIO_OUT_IRQ_EN: write 8'h01 to 8'hF2 -> irq=1 one cycle later while empty; push one word -> irq=0 the following cycle.
